image_pipe_arb: RTL and testbench
=================================

IMAGE_PIPE_ARB -- requirements
Module: image_pipe_arb

Interface
REQ-001 SHALL have parameters: DW_IN, default 32, stream data width into the pipe; DW_OUT, default 32, result data width from the pipe; TAG_DEPTH, default 4, number of frames that may be in flight in the pipe (power of 2, minimum 2).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- s0_data_in / s1_data_in  in  DW_IN  requester k input stream data
- s0_valid_in / s1_valid_in  in  1  requester k beat valid
- s0_end_in / s1_end_in  in  1  last beat of requester k frame
- s0_busy_out / s1_busy_out  out  1  stall to requester k
- r0_data_out / r1_data_out  out  DW_OUT  result data to requester k
- r0_valid_out / r1_valid_out  out  1  result beat valid to requester k
- r0_end_out / r1_end_out  out  1  last result beat to requester k
- r0_busy_in / r1_busy_in  in  1  requester k result stall
- p_data_out  out  DW_IN  to pipe is_data_in
- p_valid_out  out  1  to pipe is_valid_in
- p_end_out  out  1  to pipe is_end_in
- p_busy_in  in  1  from pipe is_busy_out
- p_data_in  in  DW_OUT  from pipe im_data_out
- p_valid_in  in  1  from pipe im_valid_out
- p_end_in  in  1  from pipe im_end_out
- p_busy_out  out  1  to pipe im_busy_in
- err  out  1  sticky: pipe produced a result with no frame outstanding

Function
REQ-003 SHALL transfer a beat on any valid/busy link in a cycle where valid=1 and busy=0; the producer holds data, valid and end stable while busy=1.
REQ-004 SHALL implement an input FSM with states IDLE and BUSY plus a registered owner bit and last-served bit.
REQ-005 In IDLE, SHALL drive s0_busy_out=s1_busy_out=1 and p_valid_out=0.
REQ-006 In IDLE with at least one sk_valid_in=1 and tag count < TAG_DEPTH, SHALL move to BUSY at the next edge, with owner set to the single requester, or to the requester other than last-served if both are valid.
REQ-007 On the IDLE->BUSY edge, SHALL push owner into the tag FIFO; grant is evaluated against the current count, so a same-cycle pop is not credited.
REQ-008 In BUSY, SHALL combinationally drive p_data_out, p_valid_out and p_end_out from the owner's inputs, drive s_owner_busy_out=p_busy_in, and hold the other requester's busy_out=1.
REQ-009 On a BUSY transfer with p_end_out=1, SHALL return to IDLE and set last-served=owner; a single-beat frame is legal.
REQ-010 SHALL let the tag FIFO head h select the result route: r_h_data_out=p_data_in, r_h_end_out=p_end_in, r_h_valid_out=p_valid_in, p_busy_out=r_h_busy_in; the non-head requester gets valid_out=0.
REQ-011 With the tag FIFO empty, SHALL drive p_busy_out=1 and both r*_valid_out=0; p_valid_in=1 in this state sets err=1 until reset.
REQ-012 SHALL pop the tag FIFO on a result transfer with p_end_in=1; push and pop in the same cycle leave the count unchanged.
REQ-013 SHALL drive r*_data_out and r*_end_out from p_data_in/p_end_in regardless of route (qualified only by valid).
REQ-014 SHALL add no added latency on either data path: the grant decision is the only registered stage, costing one idle cycle per frame.

Reset
REQ-015 rst_n=0 SHALL asynchronously force: FSM=IDLE, owner=0, last-served=1 (requester 0 wins the first tie), tag FIFO empty, err=0.
REQ-016 During reset, outputs SHALL be s*_busy_out=1, p_valid_out=0, p_busy_out=1, r*_valid_out=0; a frame in flight is abandoned, with no partial state kept.

Verification
REQ-017 Both requesters are valid at reset release, each with 3-beat frames -> grants alternate 0,1,0,1; p_end_out pulses once per frame; the gap between frames is exactly 1 cycle.
REQ-018 Requester 0 sends a 2-beat frame while p_busy_in=1 for 3 cycles mid-frame -> s0_busy_out mirrors p_busy_in, no beat is lost or duplicated, and s1_busy_out stays at 1.
REQ-019 Tag FIFO full (4 frames in flight, no results returned) -> no new grant while a 5th frame waits; after a result frame ends with p_end_in, a grant follows on the next edge.
REQ-020 Results return for tags 0,1 with r0_busy_in=1 for 2 cycles -> p_busy_out=1 for those cycles, frame 1 results reach only r1, and r1_valid_out=0 while the head is 0.
REQ-021 p_valid_in=1 with the tag FIFO empty -> err=1 on the next edge, p_busy_out=1, err stays set until rst_n=0.
REQ-022 rst_n asserted mid-frame with beat 2 of 4 -> all outputs take reset values immediately, and the next grant goes to requester 0 on a tie.

Source files
------------

// File: rtl/image_pipe_arb_if.sv
// Requester, result and pipe links of the two-requester image pipe arbiter.
// slave is the arbiter side, master is the environment side.
interface image_pipe_arb_if #(
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 32
);
  logic [DW_IN-1:0]  s0_data_in;
  logic [DW_IN-1:0]  s1_data_in;
  logic              s0_valid_in;
  logic              s1_valid_in;
  logic              s0_end_in;
  logic              s1_end_in;
  logic              s0_busy_out;
  logic              s1_busy_out;
  logic [DW_OUT-1:0] r0_data_out;
  logic [DW_OUT-1:0] r1_data_out;
  logic              r0_valid_out;
  logic              r1_valid_out;
  logic              r0_end_out;
  logic              r1_end_out;
  logic              r0_busy_in;
  logic              r1_busy_in;
  logic [DW_IN-1:0]  p_data_out;
  logic              p_valid_out;
  logic              p_end_out;
  logic              p_busy_in;
  logic [DW_OUT-1:0] p_data_in;
  logic              p_valid_in;
  logic              p_end_in;
  logic              p_busy_out;
  logic              err;

  modport slave (
    input  s0_data_in, s1_data_in,
    input  s0_valid_in, s1_valid_in,
    input  s0_end_in, s1_end_in,
    output s0_busy_out, s1_busy_out,
    output r0_data_out, r1_data_out,
    output r0_valid_out, r1_valid_out,
    output r0_end_out, r1_end_out,
    input  r0_busy_in, r1_busy_in,
    output p_data_out, p_valid_out,
    output p_end_out,
    input  p_busy_in,
    input  p_data_in, p_valid_in,
    input  p_end_in,
    output p_busy_out,
    output err
  );

  modport master (
    output s0_data_in, s1_data_in,
    output s0_valid_in, s1_valid_in,
    output s0_end_in, s1_end_in,
    input  s0_busy_out, s1_busy_out,
    input  r0_data_out, r1_data_out,
    input  r0_valid_out, r1_valid_out,
    input  r0_end_out, r1_end_out,
    output r0_busy_in, r1_busy_in,
    input  p_data_out, p_valid_out,
    input  p_end_out,
    output p_busy_in,
    output p_data_in, p_valid_in,
    output p_end_in,
    input  p_busy_out,
    input  err
  );
endinterface

// File: rtl/image_pipe_arb.sv
// Two-requester frame arbiter in front of a shared image pipe.
// A tag FIFO remembers frame owners so results route back in order.
module image_pipe_arb #(
  parameter int DW_IN     = 32,
  parameter int DW_OUT    = 32,
  parameter int TAG_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  image_pipe_arb_if.slave bus
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, BUSY} st_t;

  st_t                  st;
  logic                 owner;
  logic                 last;
  logic [TAG_DEPTH-1:0] tags;
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic [AW:0]          cnt;
  logic                 err_q;

  logic busy_st;
  logic any_v;
  logic grant;
  logic nxt_owner;
  logic in_done;
  logic empty;
  logic head;
  logic pop;

  assign busy_st   = (st == BUSY);
  assign any_v     = bus.s0_valid_in | bus.s1_valid_in;
  assign grant     = !busy_st && any_v && (cnt < FULL);
  // On a tie the requester not served last wins.
  assign nxt_owner = (bus.s0_valid_in && bus.s1_valid_in)
                     ? ~last : bus.s1_valid_in;

  assign bus.p_data_out  = owner ? bus.s1_data_in : bus.s0_data_in;
  assign bus.p_end_out   = owner ? bus.s1_end_in : bus.s0_end_in;
  assign bus.p_valid_out = busy_st &
                           (owner ? bus.s1_valid_in : bus.s0_valid_in);

  assign bus.s0_busy_out = (busy_st && !owner) ? bus.p_busy_in : 1'b1;
  assign bus.s1_busy_out = (busy_st && owner) ? bus.p_busy_in : 1'b1;

  assign in_done = bus.p_valid_out & !bus.p_busy_in & bus.p_end_out;

  assign empty = (cnt == '0);
  assign head  = tags[rp];

  assign bus.p_busy_out   = empty |
                            (head ? bus.r1_busy_in : bus.r0_busy_in);
  assign bus.r0_valid_out = !empty & !head & bus.p_valid_in;
  assign bus.r1_valid_out = !empty & head & bus.p_valid_in;
  assign bus.r0_data_out  = bus.p_data_in;
  assign bus.r1_data_out  = bus.p_data_in;
  assign bus.r0_end_out   = bus.p_end_in;
  assign bus.r1_end_out   = bus.p_end_in;
  assign bus.err          = err_q;

  assign pop = bus.p_valid_in & !bus.p_busy_out & bus.p_end_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      tags  <= '0;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (grant) begin
            st       <= BUSY;
            owner    <= nxt_owner;
            tags[wp] <= nxt_owner;
            wp       <= wp + 1'b1;
          end
        end
        BUSY: begin
          if (in_done) begin
            st   <= IDLE;
            last <= owner;
          end
        end
        default: st <= IDLE;
      endcase
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(grant) - (AW+1)'(pop);
      if (empty && bus.p_valid_in) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_image_pipe_arb.sv
// Randomized bench for image_pipe_arb against a queue-based frame model.
// Directed phases pin grant order, tag-full stall, err and mid-frame reset.
module tb_image_pipe_arb;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  image_pipe_arb_if #(.DW_IN(32), .DW_OUT(32)) bus ();

  image_pipe_arb #(
    .DW_IN(32), .DW_OUT(32), .TAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // stimulus state
  logic [1:0]  sv = '0;
  logic [1:0]  se = '0;
  logic [31:0] sd [2];
  logic [31:0] pd = '0;
  logic        pvin = 1'b0;
  logic        pe = 1'b0;
  logic        pbi = 1'b0;
  logic        rb0 = 1'b0;
  logic        rb1 = 1'b0;

  assign bus.s0_data_in  = sd[0];
  assign bus.s1_data_in  = sd[1];
  assign bus.s0_valid_in = sv[0];
  assign bus.s1_valid_in = sv[1];
  assign bus.s0_end_in   = se[0];
  assign bus.s1_end_in   = se[1];
  assign bus.p_busy_in   = pbi;
  assign bus.p_data_in   = pd;
  assign bus.p_valid_in  = pvin;
  assign bus.p_end_in    = pe;
  assign bus.r0_busy_in  = rb0;
  assign bus.r1_busy_in  = rb1;

  bit act [2];
  bit xs [2];
  int beat [2];
  int len [2];
  int fleft [2];
  int flen = 0;
  bit rnd_req = 0, rnd_res = 0, rnd_busy = 0, force_pv = 0;
  bit ract = 0, xr = 0;
  int res_left = 0;
  int ep_dut = 0;

  // behavioural model: frame owner, fairness bit, outstanding tags
  bit m_busy = 0, m_owner = 0, m_last = 1, m_err = 0;
  bit tq [$];
  bit glog [$];
  int gcyc [$];
  int cyc = 0;
  int pop_cyc = -1;
  bit nx_rst, nx_g, nx_gown, nx_done, nx_pop, nx_err;

  always begin : cmp
    logic e_sb0, e_sb1, e_pv, e_pbo, e_rv0, e_rv1, e_err, h, own_e;
    logic [31:0] own_d;
    @(negedge clk);
    #2;
    own_d = m_owner ? bus.s1_data_in : bus.s0_data_in;
    own_e = m_owner ? bus.s1_end_in : bus.s0_end_in;
    e_sb0 = 1; e_sb1 = 1; e_pv = 0; e_pbo = 1;
    e_rv0 = 0; e_rv1 = 0; e_err = 0; h = 0;
    nx_rst = !rst_n;
    nx_g = 0; nx_gown = 0; nx_done = 0; nx_pop = 0; nx_err = 0;
    if (rst_n) begin
      e_err = m_err;
      if (m_busy) begin
        e_pv = m_owner ? bus.s1_valid_in : bus.s0_valid_in;
        if (m_owner) e_sb1 = bus.p_busy_in;
        else e_sb0 = bus.p_busy_in;
      end
      if (tq.size() > 0) begin
        h = tq[0];
        e_pbo = h ? bus.r1_busy_in : bus.r0_busy_in;
        e_rv0 = !h & bus.p_valid_in;
        e_rv1 = h & bus.p_valid_in;
      end
      nx_g = !m_busy && (bus.s0_valid_in || bus.s1_valid_in)
             && tq.size() < DEPTH;
      nx_gown = (bus.s0_valid_in && bus.s1_valid_in)
                ? !m_last : bus.s1_valid_in;
      nx_done = m_busy && e_pv && !bus.p_busy_in && own_e;
      nx_pop = tq.size() > 0 && bus.p_valid_in && !e_pbo && bus.p_end_in;
      nx_err = tq.size() == 0 && bus.p_valid_in;
      if (e_pv) begin
        chk("p_data", bus.p_data_out, own_d);
        chk("p_end", bus.p_end_out, own_e);
      end
      chk("r0_data", bus.r0_data_out, bus.p_data_in);
      chk("r1_data", bus.r1_data_out, bus.p_data_in);
      chk("r0_end", bus.r0_end_out, bus.p_end_in);
      chk("r1_end", bus.r1_end_out, bus.p_end_in);
    end
    chk("s0_busy", bus.s0_busy_out, e_sb0);
    chk("s1_busy", bus.s1_busy_out, e_sb1);
    chk("p_valid", bus.p_valid_out, e_pv);
    chk("p_busy_out", bus.p_busy_out, e_pbo);
    chk("r0_valid", bus.r0_valid_out, e_rv0);
    chk("r1_valid", bus.r1_valid_out, e_rv1);
    chk("err", bus.err, e_err);
    @(posedge clk);
    if (nx_rst) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_err = 0;
      tq.delete();
    end else begin
      if (nx_pop) begin
        void'(tq.pop_front());
        pop_cyc = cyc;
      end
      if (nx_g) begin
        m_busy = 1;
        m_owner = nx_gown;
        tq.push_back(nx_gown);
        glog.push_back(nx_gown);
        gcyc.push_back(cyc);
      end
      if (nx_done) begin
        m_busy = 0;
        m_last = m_owner;
      end
      if (nx_err) m_err = 1;
    end
    cyc++;
  end

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (xs[k]) begin
        if (se[k]) act[k] = 0;
        else begin
          beat[k]++;
          sd[k] = $urandom;
          se[k] = (beat[k] == len[k] - 1);
        end
      end
      if (!act[k] && (fleft[k] > 0 ||
          (rnd_req && $urandom_range(1, 0) == 1))) begin
        if (fleft[k] > 0) fleft[k]--;
        act[k] = 1;
        beat[k] = 0;
        len[k] = flen > 0 ? flen : int'($urandom_range(4, 1));
        sd[k] = $urandom;
        se[k] = (len[k] == 1);
      end
      sv[k] = act[k];
    end
    if (xr) begin
      if (pe) ract = 0;
      else begin
        pd = $urandom;
        pe = ($urandom_range(2, 0) == 0);
      end
    end
    if (!ract && (res_left > 0 ||
        (rnd_res && tq.size() > 0 && $urandom_range(1, 0) == 1))) begin
      ract = 1;
      pd = $urandom;
      if (res_left > 0) begin
        res_left--;
        pe = 1;
      end else pe = ($urandom_range(2, 0) == 0);
    end
    pvin = ract | force_pv;
    pbi = rnd_busy && $urandom_range(9, 0) < 3;
    rb0 = rnd_busy && $urandom_range(9, 0) < 3;
    rb1 = rnd_busy && $urandom_range(9, 0) < 3;
    #3;
    xs[0] = sv[0] & !bus.s0_busy_out;
    xs[1] = sv[1] & !bus.s1_busy_out;
    xr = pvin & !bus.p_busy_out;
    if (bus.p_valid_out & bus.p_end_out & !bus.p_busy_in) ep_dut++;
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst_n = 0;
    act = '{0, 0}; xs = '{0, 0}; fleft = '{0, 0};
    sv = '0; ract = 0; xr = 0; pvin = 0;
    res_left = 0; force_pv = 0;
    #3;
    chk("rst_s0_busy", bus.s0_busy_out, 1);
    chk("rst_s1_busy", bus.s1_busy_out, 1);
    chk("rst_p_valid", bus.p_valid_out, 0);
    chk("rst_p_busy", bus.p_busy_out, 1);
    chk("rst_r0_valid", bus.r0_valid_out, 0);
    chk("rst_r1_valid", bus.r1_valid_out, 0);
    chk("rst_err", bus.err, 0);
    repeat (n) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [3:0] gs;
    int g0;
    bit ok;
    sd[0] = '0;
    sd[1] = '0;
    act = '{0, 0}; xs = '{0, 0};
    beat = '{0, 0}; len = '{0, 0}; fleft = '{0, 0};
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("init_s0_busy", bus.s0_busy_out, 1);
    chk("init_p_busy", bus.p_busy_out, 1);
    chk("init_err", bus.err, 0);

    // both requesters, two 3-beat frames each, pipe never stalls
    fleft = '{2, 2};
    flen = 3;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 60 && ep_dut < 4; i++) cycle();
    chk("frames_ended", ep_dut, 4);
    chk("grants_n", glog.size(), 4);
    if (glog.size() >= 4) begin
      gs = {glog[0], glog[1], glog[2], glog[3]};
      chk("grant_order", gs, 4'b0101);
      for (int i = 1; i < 4; i++)
        chk("frame_gap", gcyc[i] - gcyc[i-1], 4);
    end

    // tags full: fifth frame must wait
    fleft[0] = 1;
    flen = 2;
    repeat (8) cycle();
    chk("full_no_grant", glog.size(), 4);
    chk("full_s0_stall", bus.s0_busy_out, 1);
    chk("full_p_valid", bus.p_valid_out, 0);
    res_left = 1;
    for (int i = 0; i < 10 && glog.size() < 5; i++) cycle();
    chk("grant_after_pop", glog.size(), 5);
    if (glog.size() >= 5) begin
      chk("pop_to_grant", gcyc[4] - pop_cyc, 1);
      chk("fifth_owner", glog[4], 0);
    end

    // random traffic with stalls on every link
    rnd_req = 1; rnd_res = 1; rnd_busy = 1;
    flen = 0;
    repeat (3000) cycle();

    // drain everything
    rnd_req = 0;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      cycle();
      ok = !act[0] && !act[1] && !m_busy && tq.size() == 0 && !ract;
    end
    chk("drained", ok, 1);

    // stray result with nothing outstanding
    rnd_res = 0; rnd_busy = 0;
    cycle();
    force_pv = 1;
    cycle();
    force_pv = 0;
    chk("err_pre", bus.err, 0);
    chk("err_p_busy", bus.p_busy_out, 1);
    cycle();
    chk("err_set", bus.err, 1);
    repeat (3) cycle();
    chk("err_sticky", bus.err, 1);
    do_reset(1);
    cycle();
    chk("err_cleared", bus.err, 0);

    // reset during beat 2 of a 4-beat frame
    fleft[0] = 1;
    flen = 4;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      ok = act[0] && beat[0] == 1;
    end
    chk("beat2_reached", ok, 1);
    do_reset(2);
    fleft = '{1, 1};
    flen = 2;
    g0 = glog.size();
    for (int i = 0; i < 10 && glog.size() == g0; i++) cycle();
    chk("grant_after_rst", glog.size(), g0 + 1);
    if (glog.size() > g0) begin
      chk("tie_after_rst", glog[glog.size()-1], 0);
      chk("tie_owner_data", bus.p_data_out, sd[0]);
    end
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
